pulse_to_level_array: RTL and testbench

// - N-channel sticky event capture. Converts single-cycle event pulses into held levels.
// - Adds per-channel enable masking, optional rising-edge qualification and saturating hit counters.
// - Adds a lowest-index pending-event encoder with ack-based clearing.
// - Sits between linked-list datapath event sources (op done, error, full/empty hits) and the control/status logic.

---
 rtl/pulse_to_level_array_if.sv | 31 +++
 rtl/pulse_to_level_array.sv | 135 +++++++++++++
 tb/tb_pulse_to_level_array.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_to_level_array_if.sv
// Event-capture bus: pulse/enable/clear/ack requests in, sticky levels, encoder and counters out.
// Pure wiring bundle; adds no latency.
// No backpressure: the block accepts an event on every channel in every cycle.
interface pulse_to_level_array_if #(
    parameter int N     = 8,
    parameter int CNT_W = 4
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       pulse;
    logic [N-1:0]       enable;
    logic [N-1:0]       clear;
    logic               ack;
    logic [N-1:0]       level;
    logic               any_level;
    logic               first_vld;
    logic [IDX_W-1:0]   first_idx;
    logic [N*CNT_W-1:0] hit_cnt;

    // Event source / status consumer side
    modport master (
        output pulse, enable, clear, ack,
        input  level, any_level, first_vld, first_idx, hit_cnt
    );

    // Capture block side
    modport slave (
        input  pulse, enable, clear, ack,
        output level, any_level, first_vld, first_idx, hit_cnt
    );
endinterface

// File: rtl/pulse_to_level_array.sv
// N-channel sticky event capture: masked (optionally edge-qualified) pulses set held levels and saturating counters.
// Latency: event or clear/ack sampled at edge t is visible in cycle t+1; first_idx/first_vld are combinational from level.
// No backpressure; set wins over clear. Optional macro AUTO_CLEAR_EN adds per-channel TIMEOUT-cycle auto-clear timers.
module pulse_to_level_array #(
    parameter int N        = 8,
    parameter int CNT_W    = 4,
    parameter int EDGE_DET = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pulse_to_level_array_if.slave bus
);
    localparam int              IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    generate
        if (N < 1 || N > 32 || CNT_W < 1 || CNT_W > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
            $error("pulse_to_level_array: parameter out of legal range");
        end
    endgenerate

    logic [N-1:0]             level_q;
    logic [N-1:0]             level_d;
    logic [N-1:0][CNT_W-1:0]  cnt_q;
    logic [N-1:0][CNT_W-1:0]  cnt_d;
    logic [N-1:0]             ev;
    logic [N-1:0]             ack_sel;
    logic [N-1:0]             clr;
    logic [N-1:0]             expire;
    logic [IDX_W-1:0]         first_idx;

    generate
        if (EDGE_DET != 0) begin : g_edge
            logic [N-1:0] pulse_q;

            // Edge history follows the raw pulse regardless of enable, so a
            // pulse already high when enable rises is not treated as new.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pulse_q <= '0;
                end else begin
                    pulse_q <= bus.pulse;
                end
            end

            assign ev = bus.enable & bus.pulse & ~pulse_q;
        end else begin : g_level
            assign ev = bus.enable & bus.pulse;
        end
    endgenerate

    // Lowest set bit of level: x & (-x) isolates it; zero when nothing is pending,
    // which makes an ack with first_vld=0 a no-op without extra gating.
    assign ack_sel = {N{bus.ack}} & level_q & (~level_q + N'(1));
    assign clr     = bus.clear | ack_sel;

    // Priority encoder: lowest pending channel index, 0 when none pending
    always_comb begin
        first_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (level_q[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

`ifdef AUTO_CLEAR_EN
    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT);

    logic [N-1:0][15:0] tmr_q;
    logic [N-1:0][15:0] tmr_d;

    // Timer reloads on every event, counts down while the level is held,
    // and flags expiry on the 1->0 step so the level drops TIMEOUT cycles after the last event.
    always_comb begin
        tmr_d  = tmr_q;
        expire = '0;
        for (int i = 0; i < N; i++) begin
            expire[i] = level_q[i] & ~ev[i] & (tmr_q[i] == 16'd1);
            if (ev[i]) begin
                tmr_d[i] = TMR_LOAD;
            end else if (clr[i]) begin
                tmr_d[i] = '0;
            end else if (level_q[i] && tmr_q[i] != '0) begin
                tmr_d[i] = tmr_q[i] - 16'd1;
            end
        end
    end

    // Timer state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    assign expire = '0;
`endif

    // Per-channel next state: event sets and counts (wins over clear), clear/expiry zeroes, else hold
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                level_d[i] = 1'b1;
                cnt_d[i]   = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(1);
            end else if (clr[i] || expire[i]) begin
                level_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end
        end
    end

    // Level and counter state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.level     = level_q;
    assign bus.any_level = |level_q;
    assign bus.first_vld = |level_q;
    assign bus.first_idx = first_idx;
    assign bus.hit_cnt   = cnt_q;

endmodule

// File: tb/tb_pulse_to_level_array.sv
// Self-checking bench for pulse_to_level_array: one level-mode and one edge-mode instance share stimulus.
// Expectations come from directed constants and a per-channel behavioural model stepped once per clock.
// Covers AUTO_CLEAR_EN when the macro is defined for the build.
module tb_pulse_to_level_array;
    localparam int N       = 8;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 5;
    localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef AUTO_CLEAR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] pulse   = '0;
    logic [N-1:0] enable  = '0;
    logic [N-1:0] clear   = '0;
    logic         ack     = 1'b0;
    int           checks  = 0;
    int           errors  = 0;

    always #5 clk = ~clk;

    pulse_to_level_array_if #(.N(N), .CNT_W(CNT_W)) bus0 ();
    pulse_to_level_array_if #(.N(N), .CNT_W(CNT_W)) bus1 ();

    assign bus0.pulse  = pulse;
    assign bus0.enable = enable;
    assign bus0.clear  = clear;
    assign bus0.ack    = ack;
    assign bus1.pulse  = pulse;
    assign bus1.enable = enable;
    assign bus1.clear  = clear;
    assign bus1.ack    = ack;

    pulse_to_level_array #(.N(N), .CNT_W(CNT_W), .EDGE_DET(0), .TIMEOUT(TIMEOUT)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    pulse_to_level_array #(.N(N), .CNT_W(CNT_W), .EDGE_DET(1), .TIMEOUT(TIMEOUT)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    // Observed outputs, indexable by instance (0 = level mode, 1 = edge mode)
    logic [N-1:0]       o_lvl [2];
    logic [N*CNT_W-1:0] o_cnt [2];
    logic [2:0]         o_idx [2];
    logic               o_vld [2];
    logic               o_any [2];

    assign o_lvl[0] = bus0.level;     assign o_lvl[1] = bus1.level;
    assign o_cnt[0] = bus0.hit_cnt;   assign o_cnt[1] = bus1.hit_cnt;
    assign o_idx[0] = bus0.first_idx; assign o_idx[1] = bus1.first_idx;
    assign o_vld[0] = bus0.first_vld; assign o_vld[1] = bus1.first_vld;
    assign o_any[0] = bus0.any_level; assign o_any[1] = bus1.any_level;

    // Behavioural model: per channel a held flag, an event count and the edge at which it expires
    logic [N-1:0] m_lvl  [2];
    int           m_cnt  [2][N];
    int           m_dead [2][N];
    logic [N-1:0] m_prev;
    int           cyc;

    function automatic int m_first(int d);
        for (int i = 0; i < N; i++) begin
            if (m_lvl[d][i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N*CNT_W-1:0] m_cnt_vec(int d);
        logic [N*CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[d][i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lvl[d] = '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[d][i]  = 0;
                m_dead[d][i] = 0;
            end
        end
        m_prev = '0;
    endtask

    // Apply current inputs to the model, then advance the DUT one clock and settle
    task automatic step();
        int  f;
        bit  e;
        bit  c;
        for (int d = 0; d < 2; d++) begin
            f = m_first(d);
            for (int i = 0; i < N; i++) begin
                e = enable[i] && pulse[i] && (d == 0 || !m_prev[i]);
                c = clear[i] || (ack && f == i);
                if (e) begin
                    m_lvl[d][i]  = 1'b1;
                    m_cnt[d][i]  = (m_cnt[d][i] < CMAX) ? m_cnt[d][i] + 1 : CMAX;
                    m_dead[d][i] = cyc + TIMEOUT;
                end else if (c || (AUTO && m_lvl[d][i] && cyc == m_dead[d][i])) begin
                    m_lvl[d][i] = 1'b0;
                    m_cnt[d][i] = 0;
                end
            end
        end
        m_prev = pulse;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        pulse = '0;
        ack   = 1'b0;
        clear = '1;
        step();
        clear = '0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_lvl[d] !== '0 || o_cnt[d] !== '0 || o_idx[d] !== 3'd0 || o_vld[d] !== 1'b0 || o_any[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset d%0d: level=%h cnt=%h idx=%0d vld=%b any=%b, want all zero",
                         d, o_lvl[d], o_cnt[d], o_idx[d], o_vld[d], o_any[d]);
            end
        end
        #5 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        enable = '1;
        pulse  = 8'h08;
        step();
        pulse  = '0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_lvl[d] !== 8'h08 || o_cnt[d][12 +: 4] !== 4'd1 || o_idx[d] !== 3'd3 || o_vld[d] !== 1'b1) begin
                errors++;
                $display("FAIL single d%0d: level=%h cnt3=%0d idx=%0d vld=%b, want 08 1 3 1",
                         d, o_lvl[d], o_cnt[d][12 +: 4], o_idx[d], o_vld[d]);
            end
        end
        clear_all();
    endtask

    task automatic test_ack_order();
        logic [7:0] want_lvl [3];
        logic [2:0] want_idx [3];
        want_lvl[0] = 8'h24; want_idx[0] = 3'd2;
        want_lvl[1] = 8'h20; want_idx[1] = 3'd5;
        want_lvl[2] = 8'h00; want_idx[2] = 3'd0;
        pulse = 8'h24;
        step();
        pulse = '0;
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_lvl[d] !== want_lvl[k] || o_idx[d] !== want_idx[k] || o_vld[d] !== (want_lvl[k] != 8'h00)) begin
                    errors++;
                    $display("FAIL ack_order d%0d k%0d: level=%h idx=%0d vld=%b, want %h %0d",
                             d, k, o_lvl[d], o_idx[d], o_vld[d], want_lvl[k], want_idx[k]);
                end
            end
            ack = 1'b1;
            step();
        end
        ack = 1'b0;
        clear_all();
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 20; k++) begin
            pulse = 8'h01;
            step();
            pulse = '0;
            step();
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_cnt[d][3:0] !== 4'hF || o_lvl[d][0] !== 1'b1) begin
                errors++;
                $display("FAIL saturate d%0d: cnt0=%0d level0=%b, want 15 1", d, o_cnt[d][3:0], o_lvl[d][0]);
            end
        end
        clear = 8'h01;
        step();
        clear = '0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_cnt[d][3:0] !== 4'h0 || o_lvl[d][0] !== 1'b0) begin
                errors++;
                $display("FAIL sat_clear d%0d: cnt0=%0d level0=%b, want 0 0", d, o_cnt[d][3:0], o_lvl[d][0]);
            end
        end
    endtask

    task automatic test_set_wins();
        pulse = 8'h02;
        step();
        pulse = '0;
        step();
        pulse = 8'h02;
        clear = 8'h02;
        step();
        pulse = '0;
        clear = '0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_lvl[d][1] !== 1'b1 || o_cnt[d][7:4] !== 4'd2) begin
                errors++;
                $display("FAIL set_wins d%0d: level1=%b cnt1=%0d, want 1 2", d, o_lvl[d][1], o_cnt[d][7:4]);
            end
        end
        clear_all();
    endtask

    task automatic test_edge();
        pulse = 8'h10;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (o_cnt[1][19:16] !== 4'd1 || o_cnt[0][19:16] !== 4'd4) begin
            errors++;
            $display("FAIL edge_hold: edge cnt4=%0d level cnt4=%0d, want 1 4", o_cnt[1][19:16], o_cnt[0][19:16]);
        end
        clear_all();
        enable = 8'hEF;
        pulse  = 8'h10;
        step();
        enable = '1;
        step();
        step();
        checks++;
        if (o_lvl[1][4] !== 1'b0 || o_cnt[1][19:16] !== 4'd0) begin
            errors++;
            $display("FAIL edge_enable: edge level4=%b cnt4=%0d, want 0 0", o_lvl[1][4], o_cnt[1][19:16]);
        end
        checks++;
        if (o_lvl[0][4] !== 1'b1 || o_cnt[0][19:16] !== 4'd2) begin
            errors++;
            $display("FAIL level_enable: level4=%b cnt4=%0d, want 1 2", o_lvl[0][4], o_cnt[0][19:16]);
        end
        clear_all();
    endtask

    task automatic test_auto_clear();
`ifdef AUTO_CLEAR_EN
        pulse = 8'h01;
        step();
        pulse = '0;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_lvl[d][0] !== (k <= TIMEOUT)) begin
                    errors++;
                    $display("FAIL auto_single d%0d t+%0d: level0=%b want %b", d, k, o_lvl[d][0], k <= TIMEOUT);
                end
            end
            step();
        end
        pulse = 8'h01;
        step();
        pulse = '0;
        step();
        step();
        pulse = 8'h01;
        step();
        pulse = '0;
        for (int k = 4; k <= 9; k++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_lvl[d][0] !== (k <= 8) || (k == 9 && o_cnt[d][3:0] !== 4'd0)) begin
                    errors++;
                    $display("FAIL auto_retrig d%0d t+%0d: level0=%b cnt0=%0d want level %b",
                             d, k, o_lvl[d][0], o_cnt[d][3:0], k <= 8);
                end
            end
            step();
        end
`else
        pulse = 8'h01;
        step();
        pulse = '0;
        for (int k = 0; k < 12; k++) step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_lvl[d][0] !== 1'b1 || o_cnt[d][3:0] !== 4'd1) begin
                errors++;
                $display("FAIL hold_no_timer d%0d: level0=%b cnt0=%0d, want 1 1", d, o_lvl[d][0], o_cnt[d][3:0]);
            end
        end
`endif
        clear_all();
    endtask

    task automatic test_reset_mid();
        pulse = 8'hA5;
        step();
        pulse = '0;
        step();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_lvl[d] !== '0 || o_cnt[d] !== '0 || o_any[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid d%0d: level=%h cnt=%h any=%b, want zero", d, o_lvl[d], o_cnt[d], o_any[d]);
            end
        end
        #3 reset_n = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_lvl[d] !== '0 || o_cnt[d] !== '0) begin
                errors++;
                $display("FAIL reset_release d%0d: level=%h cnt=%h, want zero", d, o_lvl[d], o_cnt[d]);
            end
        end
    endtask

    task automatic test_random();
        int f;
        for (int k = 0; k < 400; k++) begin
            pulse  = 8'($urandom) & 8'($urandom);
            enable = 8'($urandom) | 8'($urandom);
            clear  = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            ack    = ($urandom_range(0, 3) == 0);
            step();
            for (int d = 0; d < 2; d++) begin
                f = m_first(d);
                checks++;
                if (o_lvl[d] !== m_lvl[d] || o_cnt[d] !== m_cnt_vec(d) ||
                    o_idx[d] !== ((f < 0) ? 3'd0 : 3'(f)) || o_vld[d] !== (f >= 0) || o_any[d] !== (f >= 0)) begin
                    errors++;
                    $display("FAIL random d%0d step %0d: level=%h/%h cnt=%h/%h idx=%0d/%0d vld=%b (got/want)",
                             d, k, o_lvl[d], m_lvl[d], o_cnt[d], m_cnt_vec(d), o_idx[d], (f < 0) ? 0 : f, o_vld[d]);
                end
            end
        end
        pulse  = '0;
        enable = '1;
        clear_all();
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_single();
        test_ack_order();
        test_saturate();
        test_set_wins();
        test_edge();
        test_auto_clear();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
